// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  // Per-cycle control bundle driven to the PC and pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic ifid_flush;
    logic dx_flush;
    logic iabort;
  } ctrl_t;

  localparam ctrl_t CTRL_FLOW   = 8'b1111_1000;  // everything advances
  localparam ctrl_t CTRL_FREEZE = 8'b0000_0000;  // everything holds

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare of decode sources against the load in ID/EX.
module load_use_detect (
  input  logic [2:0] id_rs,
  input  logic       id_rs_valid,
  input  logic [2:0] id_rt,
  input  logic       id_rt_valid,
  input  logic       dx_mem_read,
  input  logic       dx_write_reg,
  input  logic [2:0] dx_rd,
  output logic       hazard_c
);

  assign hazard_c = dx_mem_read & dx_write_reg &
                    ((id_rs_valid & (id_rs == dx_rd)) |
                     (id_rt_valid & (id_rt == dx_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  IDRs,
  input  logic        IDRsValid,
  input  logic [2:0]  IDRt,
  input  logic        IDRtValid,
  input  logic        IDHalt,
  input  logic        DXMemReadEn,
  input  logic        DXWriteToReg,
  input  logic [2:0]  DXRd,
  input  logic        XBranchTaken,
  input  logic        IMemStall,
  input  logic        DMemStall,
  output logic        PCEn,
  output logic        IFIDEn,
  output logic        DXEn,
  output logic        XMEn,
  output logic        MWEn,
  output logic        IFIDFlush,
  output logic        DXFlush,
  output logic        IAbort,
  output logic        Halted,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ctrl_t            ctrl;
  logic             load_use;

  load_use_detect u_lu (
    .id_rs        (IDRs),
    .id_rs_valid  (IDRsValid),
    .id_rt        (IDRt),
    .id_rt_valid  (IDRtValid),
    .dx_mem_read  (DXMemReadEn),
    .dx_write_reg (DXWriteToReg),
    .dx_rd        (DXRd),
    .hazard_c     (load_use)
  );

  // State and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and combinational pipeline controls; reset forces free flow.
  always_comb begin
    ctrl      = CTRL_FLOW;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!rst) begin
      case (state)
        RUN: begin
          if (DMemStall) begin
            ctrl = CTRL_FREEZE;
          end else if (XBranchTaken) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.dx_flush   = 1'b1;
            ctrl.iabort     = IMemStall;
          end else if (load_use) begin
            ctrl.pc_en    = 1'b0;
            ctrl.ifid_en  = 1'b0;
            ctrl.dx_flush = 1'b1;
          end else if (IMemStall) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
          end else if (IDHalt) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
            state_nxt       = DRAIN;
            cnt_nxt         = CNT_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (DMemStall) begin
            ctrl = CTRL_FREEZE;
          end else begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
            cnt_nxt         = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = HALTED;
          end
        end
        HALTED: ctrl = CTRL_FREEZE;
        default: state_nxt = RUN;
      endcase
    end
  end

  assign PCEn      = ctrl.pc_en;
  assign IFIDEn    = ctrl.ifid_en;
  assign DXEn      = ctrl.dx_en;
  assign XMEn      = ctrl.xm_en;
  assign MWEn      = ctrl.mw_en;
  assign IFIDFlush = ctrl.ifid_flush;
  assign DXFlush   = ctrl.dx_flush;
  assign IAbort    = ctrl.iabort;
  assign Halted    = (state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic        stall_inc, flush_inc;

  assign stall_inc = (state != HALTED) & ~ctrl.pc_en;
  assign flush_inc = (state == RUN) & ~DMemStall & XBranchTaken;

  // Saturating stall-cycle and accepted-redirect counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush_inc && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign StallCycles = stall_q;
  assign FlushCount  = flush_q;
`else
  assign StallCycles = 16'h0000;
  assign FlushCount  = 16'h0000;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It gates the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards that forwarding cannot cover, squashes wrong-path instructions on taken branches/jumps, freezes the pipe on memory stalls, and drains the pipe on halt. It sits beside the hazard/forwarding logic, fed by decode, execute and the memory interfaces.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles from halt leaving decode until it retires in WB.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- IDRs  in  3  rs field of instruction in decode
- IDRsValid  in  1  decode instruction reads rs
- IDRt  in  3  rt field of instruction in decode
- IDRtValid  in  1  decode instruction reads rt
- IDHalt  in  1  decode holds a HALT
- DXMemReadEn  in  1  ID/EX instruction is a load
- DXWriteToReg  in  1  ID/EX instruction writes a register
- DXRd  in  3  ID/EX destination register
- XBranchTaken  in  1  execute resolved a taken branch/jump (redirect)
- IMemStall  in  1  instruction memory not ready
- DMemStall  in  1  data memory not ready
- PCEn  out  1  PC register load enable
- IFIDEn, DXEn, XMEn, MWEn  out  1 each  pipeline-register enables
- IFIDFlush, DXFlush  out  1 each  load a bubble (synchronous with enable)
- IAbort  out  1  cancel in-flight fetch
- Halted  out  1  pipeline halted (sticky)
- StallCycles  out  16  perf counter (see Configuration)
- FlushCount  out  16  perf counter (see Configuration)

## Operation
States: RUN, DRAIN, HALTED. Reset enters RUN with drain counter 0.

Reset outputs:
- All enables = 1.
- All flushes = 0.
- IAbort = 0.
- Halted = 0.
- Counters = 0.

RUN priority per cycle, highest first:
1. DMemStall: PCEn, IFIDEn, DXEn, XMEn, MWEn all 0; flushes 0. A simultaneous XBranchTaken is ignored, since the branch stays in EX and is re-seen later.
2. XBranchTaken: PCEn=1. IFIDFlush=1, DXFlush=1. IAbort=1 if IMemStall. Any IDHalt or load-use this cycle is discarded.
3. Load-use: condition is DXMemReadEn & DXWriteToReg & ((IDRsValid & IDRs==DXRd) | (IDRtValid & IDRt==DXRd)). Response: PCEn=0, IFIDEn=0, DXFlush=1 for exactly one cycle. The next cycle the load is in MEM and forwarding supplies the value.
4. IMemStall: PCEn=0, IFIDFlush=1; back end runs.
5. IDHalt: go to DRAIN, load counter = DRAIN_CYCLES. PCEn=0, IFIDFlush=1.

DRAIN:
- PCEn=0, IFIDFlush=1; back end enabled.
- Counter decrements each cycle without DMemStall.
- DMemStall freezes all registers and the counter.
- At counter 1 with no stall, go to HALTED.
- XBranchTaken cannot occur, because older instructions were resolved before the halt left decode.

HALTED:
- All enables 0, Halted=1.
- Left only by rst.
- rst asserted mid-DRAIN or mid-stall returns immediately to RUN with reset outputs.

## Timing
- All enable/flush/IAbort outputs are combinational from inputs and state; no added latency.
- State and counter update on posedge clk; rst acts asynchronously.
- Load-use costs exactly 1 bubble.
- Taken branch costs 2 squashed slots.
- Halted rises DRAIN_CYCLES stall-free cycles after IDHalt is accepted.
- Flush with enable=0 never occurs; a flush implies the matching enable is 1.

## Configuration
PIPE_CTRL_PERF_EN:
- Defined: StallCycles increments, saturating at 16'hFFFF, on every cycle with PCEn=0 in RUN/DRAIN. FlushCount increments, saturating, on every accepted XBranchTaken. Both clear on rst.
- Undefined: both ports are tied to 16'h0000 and the counters are not synthesized.

## Structure
- Shared package pipe_ctrl_pkg holds the state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10) and the DRAIN_CYCLES default.
- One sub-module, load_use_detect: purely combinational compare of IDRs/IDRt against DXRd. It is reused by the verification scoreboard.

## Test plan
- LD r3 in EX, ADD using r3 in ID → one cycle of PCEn=0, IFIDEn=0, DXFlush=1, then full enables. StallCycles=1 when the perf macro is on.
- XBranchTaken with IMemStall=1 → PCEn=1, IFIDFlush=DXFlush=1, IAbort=1 for one cycle. FlushCount=1.
- DMemStall held 4 cycles with XBranchTaken=1 throughout → all enables 0 for 4 cycles. Flush fires in the 5th cycle when the stall drops.
- IDHalt alone → DRAIN. Halted=1 after 3 cycles; with DMemStall for 2 of them, after 5. All enables stay 0 afterward.
- IDHalt and XBranchTaken in the same cycle → stays RUN, flushes asserted, Halted stays 0.
- rst pulsed mid-DRAIN → outputs return to reset values asynchronously; normal fetch resumes the next cycle.
